layer_act_serializer: RTL and testbench



---
 rtl/layer_act_serializer_pkg.sv | 17 +
 rtl/layer_act_serializer_requant.sv | 31 +++
 rtl/layer_act_serializer.sv | 121 ++++++++++++
 tb/tb_layer_act_serializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_act_serializer_pkg.sv
// Shared defaults, FSM state type and index width for the layer activation serializer.
package layer_act_serializer_pkg;

  localparam int DEF_NUM_NODES    = 16;
  localparam int DEF_IN_W         = 16;
  localparam int DEF_OUT_W        = 8;
  localparam int DEF_SHIFT        = 4;
  localparam int DEF_NODE_LATENCY = 3;
  localparam int DEF_IDX_W        = $clog2(DEF_NUM_NODES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/layer_act_serializer_requant.sv
// Combinational requantizer: clip negatives to 0, shift right, saturate to the
// largest positive signed OUT_W value.
module act_requant
  import layer_act_serializer_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic [IN_W-1:0]  node_val,
  output logic [OUT_W-1:0] act
);

  localparam logic [IN_W-1:0] ACT_MAX = IN_W'(2 ** (OUT_W - 1) - 1);

  // The sign bit is handled separately, so a logical shift is enough here.
  logic [IN_W-1:0] shifted;
  assign shifted = node_val >> SHIFT;

  always_comb begin
    act = '0;
    if (node_val[IN_W-1]) begin
      act = '0;
    end else if (shifted > ACT_MAX) begin
      act = ACT_MAX[OUT_W-1:0];
    end else begin
      act = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/layer_act_serializer.sv
// Waits out the node layer latency after each launch, captures all requantized
// node outputs at once and streams them out in index order.
module layer_act_serializer
  import layer_act_serializer_pkg::*;
#(
  parameter int NUM_NODES    = DEF_NUM_NODES,
  parameter int IN_W         = DEF_IN_W,
  parameter int OUT_W        = DEF_OUT_W,
  parameter int SHIFT        = DEF_SHIFT,
  parameter int NODE_LATENCY = DEF_NODE_LATENCY
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         launch,
  input  logic [NUM_NODES*IN_W-1:0]    node_out,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [$clog2(NUM_NODES)-1:0] out_index,
  output logic                         out_last,
  output logic                         overrun,
  output logic [1:0]                   dbg_state
);

  localparam int IDX_W = $clog2(NUM_NODES);
  localparam int CNT_W = (NODE_LATENCY > 1) ? $clog2(NODE_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NODE_LATENCY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NODES - 1);

  // Stream handshake: a beat moves on any cycle where out_valid && out_ready.
  // Once out_valid is high, out_data/out_index/out_last stay fixed until that
  // beat moves; out_valid never drops without a transfer (except on reset).

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [OUT_W-1:0]  requant [NUM_NODES];
  logic [OUT_W-1:0]  buffer  [NUM_NODES];
  logic [IDX_W-1:0]  next_index;

  assign next_index = out_index + 1'b1;
  assign dbg_state  = state;

  for (genvar k = 0; k < NUM_NODES; k++) begin : g_requant
    act_requant #(
      .IN_W (IN_W),
      .OUT_W(OUT_W),
      .SHIFT(SHIFT)
    ) u_requant (
      .node_val(node_out[k*IN_W +: IN_W]),
      .act     (requant[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      buffer    <= '{default: '0};
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state   <= WAIT;
            counter <= CNT_LOAD;
            busy    <= 1'b1;
          end
        end
        WAIT: begin
          overrun <= launch;
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            buffer    <= requant;
            state     <= STREAM;
            out_valid <= 1'b1;
            out_index <= '0;
            out_data  <= requant[0];
            out_last  <= 1'b0;
          end
        end
        STREAM: begin
          if (out_ready && out_last) begin
            // Last beat leaves; a launch arriving now starts the next layer pass.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            if (launch) begin
              state   <= WAIT;
              counter <= CNT_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            overrun <= launch;
            if (out_ready) begin
              out_index <= next_index;
              out_data  <= buffer[next_index];
              out_last  <= (next_index == IDX_LAST);
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_act_serializer.sv
// Bench for layer_act_serializer: directed scenarios plus random traffic, all
// checked by a beat-level reference model with an expected-beat queue.
module tb_layer_act_serializer;
  import layer_act_serializer_pkg::*;

  localparam int NN    = DEF_NUM_NODES;
  localparam int IW    = DEF_IN_W;
  localparam int OW    = DEF_OUT_W;
  localparam int SH    = DEF_SHIFT;
  localparam int LAT   = DEF_NODE_LATENCY;
  localparam int XW    = DEF_IDX_W;
  localparam int EXP_W = 1 + XW + OW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              launch = 1'b0;
  logic [NN*IW-1:0]  node_out = '0;
  logic              busy, out_valid, out_last, overrun;
  logic              out_ready = 1'b1;
  logic [OW-1:0]     out_data;
  logic [XW-1:0]     out_index;
  logic [1:0]        dbg_state;

  layer_act_serializer dut (
    .clk      (clk),
    .reset    (reset),
    .launch   (launch),
    .node_out (node_out),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .overrun  (overrun),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [OW-1:0] ref_act(input logic [IW-1:0] v);
    int s;
    if (v[IW-1]) return '0;
    s = int'(v) / (1 << SH);
    if (s > (1 << (OW - 1)) - 1) s = (1 << (OW - 1)) - 1;
    return OW'(s);
  endfunction

  logic [EXP_W-1:0] exp_q[$];
  int   m_wait = -1;   // cycles until capture, -1 when no pass is pending
  int   m_left = 0;    // beats still owed downstream
  logic ovr_next = 1'b0;
  logic idle_now, xfer_last, accept;
  logic [EXP_W-1:0] head;

  always @(negedge clk) begin
    if (reset) begin
      m_wait   = -1;
      m_left   = 0;
      ovr_next = 1'b0;
      exp_q.delete();
    end else begin
      idle_now  = (m_wait < 0) && (m_left == 0);
      xfer_last = 1'b0;
      check("busy", busy, !idle_now);
      check("overrun", overrun, ovr_next);
      check("out_valid", out_valid, m_left > 0);
      if (m_left > 0) begin
        head = exp_q[0];
        check("out_data", out_data, head[OW-1:0]);
        check("out_index", out_index, head[OW +: XW]);
        check("out_last", out_last, head[EXP_W-1]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          m_left--;
          xfer_last = (m_left == 0);
        end
      end
      if (m_wait == 0) begin
        for (int k = 0; k < NN; k++)
          exp_q.push_back({(k == NN - 1), XW'(k), ref_act(node_out[k*IW +: IW])});
        m_left = NN;
        m_wait = -1;
      end else if (m_wait > 0) begin
        m_wait--;
      end
      accept = launch && (idle_now || xfer_last);
      if (accept) m_wait = LAT - 1;
      ovr_next = launch && !accept;
    end
  end

  // ---------------- driver tasks ----------------
  logic [IW-1:0] nv [NN];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_nodes();
    for (int k = 0; k < NN; k++) node_out[k*IW +: IW] = nv[k];
  endtask

  task automatic random_nodes();
    for (int k = 0; k < NN; k++) begin
      case ($urandom_range(0, 3))
        0: nv[k] = IW'($urandom_range(0, 16'hFFFF));
        1: nv[k] = IW'($urandom_range(0, 16'h0800));
        2: nv[k] = IW'($urandom_range(16'h07E0, 16'h0810));
        default: nv[k] = IW'($urandom_range(0, 16'h001F));
      endcase
    end
    apply_nodes();
  endtask

  task automatic wait_beat(input int idx);
    int n = 0;
    while (!(out_valid && out_index == XW'(idx)) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_beat_timeout", 0, 1);
  endtask

  // Launch in the current cycle and return the number of cycles until out_valid.
  task automatic launch_and_time(output int lat);
    launch = 1'b1;
    lat = 0;
    do begin
      tick();
      launch = 1'b0;
      lat++;
    end while (!out_valid && lat < 50);
  endtask

  task automatic drain();
    int n = 0;
    launch    = 1'b0;
    out_ready = 1'b1;
    while (!(m_wait < 0 && m_left == 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("drain_timeout", 0, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  int lat;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_last", out_last, 0);
    check("rst_overrun", overrun, 0);
    tick();

    // Ramp: node k = 16*k, full ready.
    for (int k = 0; k < NN; k++) nv[k] = IW'(16 * k);
    apply_nodes();
    launch_and_time(lat);
    check("ramp_first_valid", lat, LAT + 1);
    drain();

    // Requant corners, with a 5-cycle stall at index 3.
    random_nodes();
    nv[0] = 16'h07F0; nv[1] = 16'h7FFF; nv[2] = 16'h000F;
    nv[3] = 16'h0123; nv[4] = 16'h8000; nv[5] = 16'hFFFF;
    apply_nodes();
    launch = 1'b1;
    tick();
    launch = 1'b0;
    wait_beat(3);
    out_ready = 1'b0;
    repeat (4) tick();
    check("bp_hold_index", out_index, 3);
    check("bp_hold_data", out_data, 8'h12);
    check("bp_hold_last", out_last, 0);
    tick();
    out_ready = 1'b1;
    drain();

    // Overruns: one during WAIT, one mid-stream.
    random_nodes();
    launch = 1'b1;
    tick();
    launch = 1'b0;
    tick();
    launch = 1'b1;
    tick();
    launch = 1'b0;
    check("ovr_wait", overrun, 1);
    wait_beat(7);
    launch = 1'b1;
    tick();
    launch = 1'b0;
    check("ovr_stream", overrun, 1);
    tick();
    check("ovr_pulse_width", overrun, 0);
    drain();

    // Back-to-back launch on the last-beat transfer.
    random_nodes();
    launch = 1'b1;
    tick();
    launch = 1'b0;
    wait_beat(NN - 1);
    for (int k = 0; k < NN; k++) nv[k] = 16'h0100;
    apply_nodes();
    launch_and_time(lat);
    check("b2b_first_valid", lat, LAT + 1);
    drain();

    // Reset in the middle of a stream.
    random_nodes();
    launch = 1'b1;
    tick();
    launch = 1'b0;
    wait_beat(9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_index", out_index, 0);
    check("midrst_busy", busy, 0);
    random_nodes();
    launch_and_time(lat);
    check("postrst_first_valid", lat, LAT + 1);
    drain();

    // Random traffic: sporadic launches, random backpressure.
    for (int c = 0; c < 800; c++) begin
      launch    = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      random_nodes();
      tick();
    end
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
